itcm_port_arbiter: RTL and testbench

- Shares the single-port ITCM SRAM between three requesters:
  - instruction fetch (IF): drives the next-PC address.
  - load/store unit (LS): data access to code-space constants.
  - debug module (DBG): system-bus access while halted.
- Grant is combinational in the request cycle; read data returns one cycle later to the owner recorded at grant.
- Priority is fixed DBG > LS > IF, with a starvation guard that protects fetch against back-to-back LS traffic.
- Sits between fetch/LSU/debug and the ITCM macro, and produces the fetch-side instr_read_data_valid.

---
 rtl/itcm_port_arbiter_pkg.sv | 20 ++
 rtl/en_cnt.sv | 27 ++
 rtl/itcm_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_itcm_port_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/itcm_port_arbiter_pkg.sv
// Shared definitions for the ITCM port arbiter: owner encoding and defaults.
package itcm_port_arbiter_pkg;

  // Which requester the read data returning next cycle belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2,
    OWN_DBG  = 2'd3
  } owner_e;

  localparam int unsigned ADDR_WIDTH_DEF   = 32;
  localparam int unsigned ITCM_AW_DEF      = 14;
  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned STARVE_CW        = 4;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned BE_W             = 4;
  localparam int unsigned PERF_CW          = 32;

endpackage

// File: rtl/en_cnt.sv
// Free-running enable counter, wraps at 2^WIDTH.
// Ports: clk, rst_n (async active-low), en (count this cycle), cnt (value).
module en_cnt #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/itcm_port_arbiter.sv
// Shares the single-port ITCM SRAM between fetch (IF), load/store (LS) and
// debug (DBG). Fixed priority DBG > LS > IF with a starvation guard for IF.
// Grant and SRAM drive are combinational in the request cycle; read data is
// returned the next cycle to the owner recorded at grant.
// Ports:
//   cpu_clk, cpu_rstn          clock, async active-low reset
//   if_*                       fetch request/grant/response, if_kill flush
//   ls_*                       load/store request/grant/response
//   dbg_*                      debug request/grant/response
//   itcm_*                     SRAM macro interface
//   if_starve_cnt              count of cycles IF requested but was denied
module itcm_port_arbiter
  import itcm_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int unsigned ITCM_AW      = ITCM_AW_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_kill,
  output logic                  if_gnt,
  output logic [31:0]           if_rdata,
  output logic                  if_rdata_valid,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [3:0]            ls_be,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_gnt,
  output logic [31:0]           ls_rdata,
  output logic                  ls_rdata_valid,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [31:0]           dbg_wdata,
  output logic                  dbg_gnt,
  output logic [31:0]           dbg_rdata,
  output logic                  dbg_rdata_valid,
  output logic                  itcm_cs,
  output logic                  itcm_we,
  output logic [3:0]            itcm_be,
  output logic [ITCM_AW-1:0]    itcm_addr,
  output logic [31:0]           itcm_wdata,
  input  logic [31:0]           itcm_rdata,
  output logic [31:0]           if_starve_cnt
);

  owner_e                 owner_q;
  owner_e                 owner_d;
  logic                   kill_q;
  logic                   kill_d;
  logic [STARVE_CW-1:0]   starve_cnt_q;
  logic [STARVE_CW-1:0]   starve_cnt_d;
  logic                   starving_c;
  logic                   perf_en_c;
  logic                   unused_addr_bits;

  // Byte-lane and out-of-window address bits carry no meaning for the SRAM.
  assign unused_addr_bits = ^{if_addr[ADDR_WIDTH-1:ITCM_AW+2], if_addr[1:0],
                              ls_addr[ADDR_WIDTH-1:ITCM_AW+2], ls_addr[1:0],
                              dbg_addr[ADDR_WIDTH-1:ITCM_AW+2], dbg_addr[1:0]};

  // Grant: one winner per cycle, IF overrides LS only once starved.
  assign starving_c = (starve_cnt_q == STARVE_CW'(STARVE_LIMIT));
  assign dbg_gnt    = dbg_req;
  assign ls_gnt     = ls_req && !dbg_req && !(starving_c && if_req);
  assign if_gnt     = if_req && !dbg_req && !ls_gnt;

  // SRAM drive from the granted requester; quiet bus when idle.
  always_comb begin
    itcm_cs    = 1'b0;
    itcm_we    = 1'b0;
    itcm_be    = '0;
    itcm_addr  = '0;
    itcm_wdata = '0;
    if (dbg_gnt) begin
      itcm_cs    = 1'b1;
      itcm_we    = dbg_we;
      itcm_be    = 4'hF;
      itcm_addr  = dbg_addr[ITCM_AW+1:2];
      itcm_wdata = dbg_wdata;
    end else if (ls_gnt) begin
      itcm_cs    = 1'b1;
      itcm_we    = ls_we;
      itcm_be    = ls_be;
      itcm_addr  = ls_addr[ITCM_AW+1:2];
      itcm_wdata = ls_wdata;
    end else if (if_gnt) begin
      itcm_cs    = 1'b1;
      itcm_be    = 4'hF;
      itcm_addr  = if_addr[ITCM_AW+1:2];
    end
  end

  // Next owner, fetch-kill flag and starvation count.
  always_comb begin
    owner_d      = OWN_NONE;
    kill_d       = if_gnt && if_kill;
    starve_cnt_d = starve_cnt_q;
    if (dbg_gnt && !dbg_we)     owner_d = OWN_DBG;
    else if (ls_gnt && !ls_we)  owner_d = OWN_LS;
    else if (if_gnt)            owner_d = OWN_IF;

    // Debug traffic freezes the count so it never looks like starvation.
    if (dbg_req) begin
      starve_cnt_d = starve_cnt_q;
    end else if (if_gnt || !if_req) begin
      starve_cnt_d = '0;
    end else if (!starving_c) begin
      starve_cnt_d = starve_cnt_q + STARVE_CW'(1);
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      owner_q      <= OWN_NONE;
      kill_q       <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      owner_q      <= owner_d;
      kill_q       <= kill_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Response: valid follows the registered owner; a kill in either the
  // grant cycle (kill_q) or the response cycle (if_kill) drops the fetch.
  assign if_rdata_valid  = (owner_q == OWN_IF) && !kill_q && !if_kill;
  assign ls_rdata_valid  = (owner_q == OWN_LS);
  assign dbg_rdata_valid = (owner_q == OWN_DBG);
  assign if_rdata        = if_rdata_valid  ? itcm_rdata : '0;
  assign ls_rdata        = ls_rdata_valid  ? itcm_rdata : '0;
  assign dbg_rdata       = dbg_rdata_valid ? itcm_rdata : '0;

  // Performance counter counts every denied fetch cycle, debug included.
  assign perf_en_c = if_req && !if_gnt;

  en_cnt #(
    .WIDTH (PERF_CW)
  ) u_starve_perf (
    .clk   (cpu_clk),
    .rst_n (cpu_rstn),
    .en    (perf_en_c),
    .cnt   (if_starve_cnt)
  );

endmodule

// File: tb/tb_itcm_port_arbiter.sv
// Directed bench for itcm_port_arbiter with a behavioural one-cycle SRAM.
module tb_itcm_port_arbiter;

  logic        cpu_clk;
  logic        cpu_rstn;
  logic        if_req, if_kill, if_gnt, if_rdata_valid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rdata_valid;
  logic [3:0]  ls_be;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        dbg_req, dbg_we, dbg_gnt, dbg_rdata_valid;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        itcm_cs, itcm_we;
  logic [3:0]  itcm_be;
  logic [13:0] itcm_addr;
  logic [31:0] itcm_wdata, itcm_rdata;
  logic [31:0] if_starve_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [256];

  itcm_port_arbiter dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_gnt(if_gnt),
    .if_rdata(if_rdata), .if_rdata_valid(if_rdata_valid),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rdata(ls_rdata),
    .ls_rdata_valid(ls_rdata_valid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata),
    .dbg_rdata_valid(dbg_rdata_valid),
    .itcm_cs(itcm_cs), .itcm_we(itcm_we), .itcm_be(itcm_be),
    .itcm_addr(itcm_addr), .itcm_wdata(itcm_wdata), .itcm_rdata(itcm_rdata),
    .if_starve_cnt(if_starve_cnt)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // SRAM model: byte-masked write, read data valid the cycle after select.
  always @(posedge cpu_clk) begin
    if (itcm_cs) begin
      if (itcm_we) begin
        for (int b = 0; b < 4; b++)
          if (itcm_be[b]) mem[itcm_addr[7:0]][8*b +: 8] <= itcm_wdata[8*b +: 8];
      end else begin
        itcm_rdata <= mem[itcm_addr[7:0]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drv_if(input logic r, input logic [31:0] a, input logic k);
    if_req = r; if_addr = a; if_kill = k;
  endtask

  task automatic drv_ls(input logic r, input logic w, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] d);
    ls_req = r; ls_we = w; ls_be = be; ls_addr = a; ls_wdata = d;
  endtask

  task automatic drv_dbg(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d);
    dbg_req = r; dbg_we = w; dbg_addr = a; dbg_wdata = d;
  endtask

  task automatic idle();
    drv_if(1'b0, 32'h0, 1'b0);
    drv_ls(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drv_dbg(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic all_valids(input string tag);
    check({tag, "_ifv"},  32'(if_rdata_valid),  32'h0);
    check({tag, "_lsv"},  32'(ls_rdata_valid),  32'h0);
    check({tag, "_dbgv"}, 32'(dbg_rdata_valid), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_ls;
    logic prev_ls, prev_if;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]    = 32'h0000_0013;
    mem[1]    = 32'h0010_0093;
    mem[2]    = 32'h0020_0113;
    mem[16]   = 32'hDEAD_BEEF;
    mem[32]   = 32'h1122_3344;
    mem[64]   = 32'hCAFE_F00D;
    itcm_rdata = 32'h0;
    cpu_rstn  = 1'b0;
    idle();
    repeat (2) @(posedge cpu_clk);
    @(negedge cpu_clk); #1;
    all_valids("rst");
    check("rst_perf", if_starve_cnt, 32'h0);
    check("rst_cs", 32'(itcm_cs), 32'h0);
    cpu_rstn = 1'b1;

    // IF-only back-to-back fetches
    @(negedge cpu_clk); drv_if(1'b1, 32'h0, 1'b0); #1;
    check("if0_gnt", 32'(if_gnt), 32'h1);
    check("if0_addr", 32'(itcm_addr), 32'h0);
    check("if0_v", 32'(if_rdata_valid), 32'h0);
    @(negedge cpu_clk); drv_if(1'b1, 32'h4, 1'b0); #1;
    check("if1_gnt", 32'(if_gnt), 32'h1);
    check("if1_v", 32'(if_rdata_valid), 32'h1);
    check("if1_d", if_rdata, 32'h0000_0013);
    @(negedge cpu_clk); drv_if(1'b1, 32'h8, 1'b0); #1;
    check("if2_gnt", 32'(if_gnt), 32'h1);
    check("if2_v", 32'(if_rdata_valid), 32'h1);
    check("if2_d", if_rdata, 32'h0010_0093);
    @(negedge cpu_clk); idle(); #1;
    check("if3_gnt", 32'(if_gnt), 32'h0);
    check("if3_cs", 32'(itcm_cs), 32'h0);
    check("if3_v", 32'(if_rdata_valid), 32'h1);
    check("if3_d", if_rdata, 32'h0020_0113);
    @(negedge cpu_clk); #1;
    check("if4_v", 32'(if_rdata_valid), 32'h0);
    check("if4_d", if_rdata, 32'h0);

    // LS and IF collide: LS wins
    @(negedge cpu_clk);
    drv_if(1'b1, 32'hC, 1'b0); drv_ls(1'b1, 1'b0, 4'hF, 32'h40, 32'h0); #1;
    check("col_ls_gnt", 32'(ls_gnt), 32'h1);
    check("col_if_gnt", 32'(if_gnt), 32'h0);
    check("col_addr", 32'(itcm_addr), 32'h10);
    @(negedge cpu_clk); idle(); #1;
    check("col_lsv", 32'(ls_rdata_valid), 32'h1);
    check("col_lsd", ls_rdata, 32'hDEAD_BEEF);
    check("col_ifv", 32'(if_rdata_valid), 32'h0);
    check("col_perf", if_starve_cnt, 32'h1);

    // Sustained LS with IF requesting: period-5 pattern, 4 LS then 1 IF
    prev_ls = 1'b0; prev_if = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge cpu_clk);
      drv_if(1'b1, 32'h0, 1'b0); drv_ls(1'b1, 1'b0, 4'hF, 32'h40, 32'h0); #1;
      exp_ls = ((k % 5) != 4);
      check($sformatf("stv%0d_ls", k), 32'(ls_gnt), 32'(exp_ls));
      check($sformatf("stv%0d_if", k), 32'(if_gnt), 32'(!exp_ls));
      check($sformatf("stv%0d_perf", k), if_starve_cnt, 32'(1 + k - k / 5));
      if (k > 0) begin
        check($sformatf("stv%0d_lsv", k), 32'(ls_rdata_valid), 32'(prev_ls));
        check($sformatf("stv%0d_ifv", k), 32'(if_rdata_valid), 32'(prev_if));
      end
      prev_ls = exp_ls; prev_if = !exp_ls;
    end

    // Debug preempts everything and freezes the starvation count at 2
    for (int k = 0; k < 2; k++) begin
      @(negedge cpu_clk);
      drv_if(1'b1, 32'h0, 1'b0); drv_ls(1'b1, 1'b0, 4'hF, 32'h40, 32'h0); #1;
      check($sformatf("pre%0d_ls", k), 32'(ls_gnt), 32'h1);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge cpu_clk); drv_dbg(1'b1, 1'b0, 32'h8, 32'h0); #1;
      check($sformatf("dbg%0d_gnt", k), 32'(dbg_gnt), 32'h1);
      check($sformatf("dbg%0d_ls", k), 32'(ls_gnt), 32'h0);
      check($sformatf("dbg%0d_if", k), 32'(if_gnt), 32'h0);
      check($sformatf("dbg%0d_addr", k), 32'(itcm_addr), 32'h2);
      if (k > 0) check($sformatf("dbg%0d_d", k), dbg_rdata, 32'h0020_0113);
    end
    @(negedge cpu_clk); drv_dbg(1'b0, 1'b0, 32'h0, 32'h0); #1;
    check("res0_ls", 32'(ls_gnt), 32'h1);
    check("res0_dbgv", 32'(dbg_rdata_valid), 32'h1);
    @(negedge cpu_clk); #1;
    check("res1_ls", 32'(ls_gnt), 32'h1);
    check("res1_dbgv", 32'(dbg_rdata_valid), 32'h0);
    @(negedge cpu_clk); #1;
    check("res2_if", 32'(if_gnt), 32'h1);
    check("res2_ls", 32'(ls_gnt), 32'h0);
    @(negedge cpu_clk); idle(); #1;
    check("res3_ifv", 32'(if_rdata_valid), 32'h1);
    check("res3_perf", if_starve_cnt, 32'd16);

    // Kill in the grant cycle
    @(negedge cpu_clk); drv_if(1'b1, 32'h100, 1'b1); #1;
    check("kg_gnt", 32'(if_gnt), 32'h1);
    check("kg_addr", 32'(itcm_addr), 32'h40);
    @(negedge cpu_clk); idle(); #1;
    check("kg_v", 32'(if_rdata_valid), 32'h0);
    check("kg_d", if_rdata, 32'h0);

    // Kill in the response cycle; upper address bits ignored
    @(negedge cpu_clk); drv_if(1'b1, 32'hF000_0100, 1'b0); #1;
    check("kr_gnt", 32'(if_gnt), 32'h1);
    check("kr_addr", 32'(itcm_addr), 32'h40);
    @(negedge cpu_clk); drv_if(1'b0, 32'h0, 1'b1); #1;
    check("kr_v", 32'(if_rdata_valid), 32'h0);
    check("kr_d", if_rdata, 32'h0);
    @(negedge cpu_clk); drv_if(1'b1, 32'h100, 1'b0); #1;
    check("kn_gnt", 32'(if_gnt), 32'h1);
    @(negedge cpu_clk); idle(); #1;
    check("kn_v", 32'(if_rdata_valid), 32'h1);
    check("kn_d", if_rdata, 32'hCAFE_F00D);

    // LS partial write beats a concurrent IF read, no response for a write
    @(negedge cpu_clk);
    drv_if(1'b1, 32'h0, 1'b0); drv_ls(1'b1, 1'b1, 4'b0011, 32'h80, 32'hAAAA_5555); #1;
    check("wr_ls", 32'(ls_gnt), 32'h1);
    check("wr_if", 32'(if_gnt), 32'h0);
    check("wr_we", 32'(itcm_we), 32'h1);
    check("wr_be", 32'(itcm_be), 32'h3);
    check("wr_addr", 32'(itcm_addr), 32'h20);
    check("wr_wd", itcm_wdata, 32'hAAAA_5555);
    @(negedge cpu_clk); idle(); drv_ls(1'b1, 1'b0, 4'hF, 32'h80, 32'h0); #1;
    check("rb_gnt", 32'(ls_gnt), 32'h1);
    check("rb_we", 32'(itcm_we), 32'h0);
    check("rb_be", 32'(itcm_be), 32'hF);
    check("wr_lsv", 32'(ls_rdata_valid), 32'h0);
    check("wr_ifv", 32'(if_rdata_valid), 32'h0);
    check("wr_perf", if_starve_cnt, 32'd17);
    @(negedge cpu_clk); idle(); #1;
    check("rb_v", 32'(ls_rdata_valid), 32'h1);
    check("rb_d", ls_rdata, 32'h1122_5555);
    check("idle_cs", 32'(itcm_cs), 32'h0);
    check("idle_addr", 32'(itcm_addr), 32'h0);

    // Reset during an outstanding debug response
    @(negedge cpu_clk); drv_dbg(1'b1, 1'b0, 32'h4, 32'h0); #1;
    check("rd_gnt", 32'(dbg_gnt), 32'h1);
    @(negedge cpu_clk); idle(); #1;
    check("rd_v", 32'(dbg_rdata_valid), 32'h1);
    check("rd_d", dbg_rdata, 32'h0010_0093);
    cpu_rstn = 1'b0; #1;
    all_valids("rr0");
    check("rr0_d", dbg_rdata, 32'h0);
    check("rr0_perf", if_starve_cnt, 32'h0);
    @(negedge cpu_clk); #1;
    all_valids("rr1");
    cpu_rstn = 1'b1; #1;
    all_valids("rr2");
    @(negedge cpu_clk); #1;
    all_valids("rr3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
